// File: rtl/gpu_fb_ctrl_if.sv
// gpu_fb_ctrl_if -- bus bundle for the framebuffer controller.
//
// Groups the CPU request/ack port, the fill-engine controls and the VGA scan
// port. The controller connects through the slave modport, the requester or
// bench through the master modport.
//
// Handshake rules:
//   cpu_req_i is a level held by the requester until it sees cpu_ack_o. The
//   controller samples cpu_we_i, cpu_x_i, cpu_y_i and cpu_wdata_i on the same
//   edge that accepts the request. cpu_ack_o pulses for exactly one cycle, and
//   cpu_rdata_o and cpu_err_o are meaningful in that cycle. The requester must
//   drop cpu_req_i in the ack cycle; a request still high afterwards is treated
//   as a new one. fill_start_i is a single-cycle strobe sampled only when idle,
//   and fill_busy_o stays high for the whole fill. The scan port takes no
//   handshake: one coordinate in each cycle, one pixel out one cycle later.
//
// Signals:
//   cpu_req_i, cpu_we_i, cpu_x_i, cpu_y_i, cpu_wdata_i   CPU request side
//   cpu_rdata_o, cpu_ack_o, cpu_err_o                     CPU completion side
//   fill_start_i, fill_color_i, fill_busy_o               fill engine
//   scan_en_i, scan_x_i, scan_y_i, scan_data_o,
//   scan_valid_o                                          VGA scan-out
//   dbg_state                                             port B FSM state
interface gpu_fb_ctrl_if #(
  parameter int PIX_W   = 12,
  parameter int COORD_W = 8
);
  logic               cpu_req_i;
  logic               cpu_we_i;
  logic [COORD_W-1:0] cpu_x_i;
  logic [COORD_W-1:0] cpu_y_i;
  logic [PIX_W-1:0]   cpu_wdata_i;
  logic [PIX_W-1:0]   cpu_rdata_o;
  logic               cpu_ack_o;
  logic               cpu_err_o;
  logic               fill_start_i;
  logic [PIX_W-1:0]   fill_color_i;
  logic               fill_busy_o;
  logic               scan_en_i;
  logic [COORD_W-1:0] scan_x_i;
  logic [COORD_W-1:0] scan_y_i;
  logic [PIX_W-1:0]   scan_data_o;
  logic               scan_valid_o;
  logic [1:0]         dbg_state;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_x_i, cpu_y_i, cpu_wdata_i,
    output cpu_rdata_o, cpu_ack_o, cpu_err_o,
    input  fill_start_i, fill_color_i,
    output fill_busy_o,
    input  scan_en_i, scan_x_i, scan_y_i,
    output scan_data_o, scan_valid_o,
    output dbg_state
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_x_i, cpu_y_i, cpu_wdata_i,
    input  cpu_rdata_o, cpu_ack_o, cpu_err_o,
    output fill_start_i, fill_color_i,
    input  fill_busy_o,
    output scan_en_i, scan_x_i, scan_y_i,
    input  scan_data_o, scan_valid_o,
    input  dbg_state
  );
endinterface

// File: rtl/gpu_fb_ctrl.sv
// gpu_fb_ctrl -- dual-port framebuffer controller for the VGA GPU path.
//
// Port A is the VGA scan-out read (1-cycle latency, never stalls). Port B is
// shared by CPU read/write requests and a whole-frame fill engine, sequenced
// by a four-state FSM (IDLE, ACC, ACK, FILL). Frame buffer contents are not
// reset; all registered outputs and the FSM are.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    gpu_fb_ctrl_if.slave (CPU, fill and scan signals, FSM state)
//
// Build option:
//   GPU_FB_SCAN_BORDER_EN  when defined, an enabled scan of an out-of-range
//                          coordinate returns all-ones (border colour) with
//                          scan_valid_o low; otherwise it returns zero.
module gpu_fb_ctrl #(
  parameter int H_RES   = 200,
  parameter int V_RES   = 150,
  parameter int PIX_W   = 12,
  parameter int COORD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  gpu_fb_ctrl_if.slave      bus
);
  localparam int DEPTH  = H_RES * V_RES;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int unsigned H_LIM = H_RES;
  localparam int unsigned V_LIM = V_RES;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC = 2'd1, S_ACK = 2'd2, S_FILL = 2'd3} state_t;

  localparam addr_t LAST_ADDR = addr_t'(DEPTH - 1);

  function automatic logic in_range(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    return (32'(x) < H_LIM) && (32'(y) < V_LIM);
  endfunction

  // Only meaningful for in-range coordinates, where the result fits ADDR_W.
  function automatic addr_t lin_addr(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    return addr_t'(y) * addr_t'(H_RES) + addr_t'(x);
  endfunction

  logic [PIX_W-1:0] mem [DEPTH];

  state_t           state;
  logic             we_q;
  logic             err_q;
  addr_t            addr_q;
  logic [PIX_W-1:0] wdata_q;
  logic [PIX_W-1:0] fill_color_q;
  addr_t            fill_cnt;
  logic [PIX_W-1:0] cpu_rdata_q;
  logic             cpu_ack_q;
  logic             cpu_err_q;
  logic             fill_busy_q;
  logic [PIX_W-1:0] scan_data_q;
  logic             scan_valid_q;

  logic             ram_we;
  addr_t            ram_waddr;
  logic [PIX_W-1:0] ram_wdata;
  logic             scan_hit;
  addr_t            scan_addr;

  // Port B write mux: the fill engine owns the port in FILL, the CPU in ACC.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = fill_cnt;
    ram_wdata = fill_color_q;
    if (state == S_FILL) begin
      ram_we = 1'b1;
    end else if (state == S_ACC && we_q && !err_q) begin
      ram_we    = 1'b1;
      ram_waddr = addr_q;
      ram_wdata = wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  // Scan port: reads the pre-edge contents, so a same-cycle write is not seen.
  assign scan_hit  = bus.scan_en_i && in_range(bus.scan_x_i, bus.scan_y_i);
  assign scan_addr = lin_addr(bus.scan_x_i, bus.scan_y_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_data_q  <= '0;
      scan_valid_q <= 1'b0;
    end else if (scan_hit) begin
      scan_data_q  <= mem[scan_addr];
      scan_valid_q <= 1'b1;
    end else begin
`ifdef GPU_FB_SCAN_BORDER_EN
      scan_data_q  <= bus.scan_en_i ? {PIX_W{1'b1}} : '0;
`else
      scan_data_q  <= '0;
`endif
      scan_valid_q <= 1'b0;
    end
  end

  // Port B sequencer. Fill is checked before CPU requests so a simultaneous
  // request stays pending and is picked up when FILL returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      fill_color_q <= '0;
      fill_cnt     <= '0;
      cpu_rdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      cpu_err_q    <= 1'b0;
      fill_busy_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.fill_start_i) begin
            fill_color_q <= bus.fill_color_i;
            fill_cnt     <= '0;
            fill_busy_q  <= 1'b1;
            state        <= S_FILL;
          end else if (bus.cpu_req_i) begin
            we_q    <= bus.cpu_we_i;
            err_q   <= !in_range(bus.cpu_x_i, bus.cpu_y_i);
            addr_q  <= lin_addr(bus.cpu_x_i, bus.cpu_y_i);
            wdata_q <= bus.cpu_wdata_i;
            state   <= S_ACC;
          end
        end
        S_ACC: begin
          // Ack and read data are registered here so they appear in ACK.
          cpu_ack_q <= 1'b1;
          cpu_err_q <= err_q;
          if (!we_q && !err_q) cpu_rdata_q <= mem[addr_q];
          state <= S_ACK;
        end
        S_ACK: begin
          cpu_ack_q <= 1'b0;
          cpu_err_q <= 1'b0;
          state     <= S_IDLE;
        end
        S_FILL: begin
          if (fill_cnt == LAST_ADDR) begin
            fill_busy_q <= 1'b0;
            state       <= S_IDLE;
          end else begin
            fill_cnt <= fill_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cpu_rdata_o  = cpu_rdata_q;
  assign bus.cpu_ack_o    = cpu_ack_q;
  assign bus.cpu_err_o    = cpu_err_q;
  assign bus.fill_busy_o  = fill_busy_q;
  assign bus.scan_data_o  = scan_data_q;
  assign bus.scan_valid_o = scan_valid_q;
  assign bus.dbg_state    = state;
endmodule
